// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants for the FIFO stream reader
// Purpose: legal read-latency range, buffer depth helper and pointer sizing
//          used by fifo_stream_reader and fifo_rd_buf.
// Ports:   none (package).
// Config:  FIFO_RD_STATS_EN (used by fifo_stream_reader) enables word_count.
package fifo_rd_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;
  localparam int WIDTH_MIN      = 4;
  localparam int WIDTH_MAX      = 36;

  // The buffer needs one slot per in-flight read plus one being drained.
  localparam int BUF_DEPTH_MAX  = RD_LATENCY_MAX + 1;
  localparam int PTR_W          = 2;
  localparam int MEM_N          = 1 << PTR_W;

  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// rtl/fifo_rd_buf.sv - small circular buffer behind the FIFO read pipeline
// Purpose: DEPTH-entry circular buffer; pointers wrap modulo DEPTH.
// Ports:   clk, rst_n     - clock, asynchronous active-low reset
//          clr            - synchronous clear of pointers and count (wins)
//          wr_en, wr_data - push one word
//          rd_en          - pop head word (caller guarantees rd_valid)
//          rd_valid       - buffer not empty
//          rd_data        - head word
//          count          - buffered word count
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);

  // Storage is sized to the pointer range; only the first DEPTH slots are used.
  logic [WIDTH-1:0] mem_q [MEM_N];
  logic [WIDTH-1:0] mem_d [MEM_N];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_en) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - standard-mode FIFO to valid/ready stream adapter
// Purpose: issues credit-limited reads to an upstream FIFO with RD_LATENCY
//          read latency, buffers returning words and presents them as a stream.
// Ports:   clk, rst_n             - clock, asynchronous active-low reset
//          fifo_empty, fifo_rd_en - upstream FIFO flag and read strobe
//          fifo_dout              - upstream data, valid RD_LATENCY after read
//          flush                  - discard buffered and in-flight words
//          m_valid, m_ready       - stream handshake
//          m_data                 - stream word
//          occupancy              - buffered word count
//          word_count             - delivered-word statistic
// Config:  FIFO_RD_STATS_EN enables the saturating word_count; otherwise 0.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy,
  output logic [15:0]      word_count
);

  localparam int DEPTH = buf_depth(RD_LATENCY);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX ||
      WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_param_check
    $error("fifo_stream_reader: illegal WIDTH or RD_LATENCY");
  end

  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [2:0]            inflight_cnt;
  logic [3:0]            committed;
  logic                  rd_en;
  logic                  pop;
  logic                  arrive;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + 3'(inflight_q[i]);
    end
  end

  // Words already owed to the buffer once this cycle's pop is accounted for;
  // a new read is only allowed if it still fits.
  assign committed = 4'(inflight_cnt) + 4'(occupancy) - 4'(m_valid && m_ready);
  assign rd_en     = rst_n && !fifo_empty && !flush && (committed < 4'(DEPTH));
  assign fifo_rd_en = rd_en;

  assign pop    = m_valid && m_ready;
  assign arrive = inflight_q[RD_LATENCY-1];

  always_comb begin
    inflight_d = '0;
    if (!flush) begin
      inflight_d[0] = rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        inflight_d[i] = inflight_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // The buffer's clear input takes priority over a same-cycle push and pop.
  fifo_rd_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .wr_en    (arrive),
    .wr_data  (fifo_dout),
    .rd_en    (pop),
    .rd_valid (m_valid),
    .rd_data  (m_data),
    .count    (occupancy)
  );

`ifdef FIFO_RD_STATS_EN
  logic [15:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (pop && !flush && word_count_q != 16'hFFFF) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - bench for fifo_stream_reader at latency 1 and 2
module tb_fifo_stream_reader;

  typedef struct packed {
    logic [35:0] w;
    logic [31:0] c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        empty_a [2];
  logic        flush_a [2];
  logic        rdy_a   [2];
  logic [8:0]  dout0;
  logic [35:0] dout1;
  logic        rd0, rd1, mv0, mv1;
  logic [8:0]  md0;
  logic [35:0] md1;
  logic [1:0]  occ0, occ1;
  logic [15:0] wc0, wc1;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(9), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty_a[0]), .fifo_rd_en(rd0),
    .fifo_dout(dout0), .flush(flush_a[0]), .m_valid(mv0), .m_ready(rdy_a[0]),
    .m_data(md0), .occupancy(occ0), .word_count(wc0)
  );

  fifo_stream_reader #(.WIDTH(36), .RD_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty_a[1]), .fifo_rd_en(rd1),
    .fifo_dout(dout1), .flush(flush_a[1]), .m_valid(mv1), .m_ready(rdy_a[1]),
    .m_data(md1), .occupancy(occ1), .word_count(wc1)
  );

  // Upstream FIFO contents, words read but not yet delivered (with read cycle),
  // and the upstream read-data pipeline.
  logic [35:0] upq [2][$];
  ent_t        exq [2][$];
  logic [35:0] pipe [2][2];
  logic        fe [2];
  int          delivered [2];
  logic [15:0] wc_exp [2];
  logic [31:0] cyc;
  logic        rst_pulse;
  int          checks, failures;

  logic        last_rd [2];
  logic        last_v [2];
  logic [35:0] last_d [2];
  logic [1:0]  last_occ [2];

  int rd_cnt, rd_run, rd_best, v_run, v_best, first_rd, first_v, d_base;
  int unstable, seen, rem0, rem1, d_base1;
  logic [35:0] hold;

  function automatic int lat(input int i);
    return i + 1;
  endfunction

  function automatic int depth(input int i);
    return i + 2;
  endfunction

  function automatic logic [35:0] mask(input int i);
    return (i == 0) ? 36'h1FF : {36{1'b1}};
  endfunction

  function automatic logic [35:0] rnd(input int i);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[35:0] & mask(i);
  endfunction

  task automatic chk(input int inst, input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL dut%0d %s observed=%0h expected=%0h", inst, tag, obs, exp);
    end
  endtask

  // One clock cycle: entered just after a falling edge with rdy/flush/fe set.
  task automatic cycle();
    logic [35:0] sd [2];
    logic        srd [2];
    logic        sv [2];
    logic [1:0]  socc [2];
    logic [15:0] swc [2];
    logic [35:0] newin [2];
    int          arrived, infl;
    logic        pop_exp, rd_exp;
    for (int i = 0; i < 2; i++) empty_a[i] = (upq[i].size() == 0) || fe[i];
    if (rst_pulse) begin
      #1;
      rst_n = 1'b0;
    end
    #1;
    srd[0] = rd0;  srd[1] = rd1;
    sv[0]  = mv0;  sv[1]  = mv1;
    sd[0]  = {27'b0, md0};  sd[1] = md1;
    socc[0] = occ0; socc[1] = occ1;
    swc[0] = wc0;  swc[1] = wc1;
    for (int i = 0; i < 2; i++) begin
      newin[i]    = rnd(i);
      last_rd[i]  = srd[i];
      last_v[i]   = sv[i];
      last_d[i]   = sd[i];
      last_occ[i] = socc[i];
      if (!rst_n) begin
        chk(i, "reset_m_valid", 64'(sv[i]), 64'd0);
        chk(i, "reset_occupancy", 64'(socc[i]), 64'd0);
        chk(i, "reset_fifo_rd_en", 64'(srd[i]), 64'd0);
        chk(i, "reset_m_data", 64'(sd[i]), 64'd0);
        chk(i, "reset_word_count", 64'(swc[i]), 64'd0);
        exq[i].delete();
        wc_exp[i] = '0;
      end else begin
        arrived = 0;
        for (int k = 0; k < exq[i].size(); k++) begin
          if (exq[i][k].c + 32'(lat(i)) + 32'd1 <= cyc) arrived++;
        end
        chk(i, "occupancy", 64'(socc[i]), 64'(arrived));
        chk(i, "m_valid", 64'(sv[i]), 64'(arrived != 0));
        if (arrived != 0) chk(i, "m_data", 64'(sd[i]), 64'(exq[i][0].w));
        chk(i, "word_count", 64'(swc[i]), 64'(wc_exp[i]));
        pop_exp = (arrived != 0) && rdy_a[i];
        infl    = exq[i].size() - arrived;
        rd_exp  = !empty_a[i] && !flush_a[i] &&
                  ((infl + arrived - int'(pop_exp)) < depth(i));
        chk(i, "fifo_rd_en", 64'(srd[i]), 64'(rd_exp));
        if (flush_a[i]) begin
          exq[i].delete();
        end else if (pop_exp) begin
          void'(exq[i].pop_front());
          delivered[i]++;
`ifdef FIFO_RD_STATS_EN
          if (wc_exp[i] != 16'hFFFF) wc_exp[i] = wc_exp[i] + 16'd1;
`endif
        end
        if (srd[i] && !empty_a[i]) begin
          newin[i] = upq[i].pop_front();
          if (!flush_a[i]) exq[i].push_back('{w: newin[i], c: cyc});
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      pipe[i][1] = pipe[i][0];
      pipe[i][0] = newin[i];
    end
    dout0 = pipe[0][0][8:0];
    dout1 = pipe[1][1];
    cyc++;
    @(negedge clk);
    rst_n     = 1'b1;
    rst_pulse = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = '0;
    rst_n = 1'b1; rst_pulse = 1'b1;
    for (int i = 0; i < 2; i++) begin
      empty_a[i] = 1'b1; flush_a[i] = 1'b0; rdy_a[i] = 1'b0; fe[i] = 1'b0;
      delivered[i] = 0; wc_exp[i] = '0;
      pipe[i][0] = '0; pipe[i][1] = '0;
    end
    dout0 = '0; dout1 = '0;

    // Reset state, then idle.
    cycle();
    repeat (2) cycle();

    // Latency 1: eight words streamed back to back with m_ready held high.
    for (int k = 0; k < 8; k++) upq[0].push_back(rnd(0));
    rdy_a[0] = 1'b1;
    rd_cnt = 0; rd_run = 0; rd_best = 0; v_run = 0; v_best = 0;
    first_rd = -1; first_v = -1; d_base = delivered[0];
    for (int n = 0; n < 14; n++) begin
      cycle();
      if (last_rd[0]) begin
        rd_cnt++; rd_run++;
        if (first_rd < 0) first_rd = n;
      end else rd_run = 0;
      if (rd_run > rd_best) rd_best = rd_run;
      if (last_v[0]) begin
        v_run++;
        if (first_v < 0) first_v = n;
      end else v_run = 0;
      if (v_run > v_best) v_best = v_run;
    end
    chk(0, "burst_rd_pulses", 64'(rd_cnt), 64'd8);
    chk(0, "burst_rd_consecutive", 64'(rd_best), 64'd8);
    chk(0, "burst_valid_consecutive", 64'(v_best), 64'd8);
    chk(0, "burst_latency", 64'(first_v - first_rd), 64'd2);
    chk(0, "burst_delivered", 64'(delivered[0] - d_base), 64'd8);

    // Latency 2, stalled consumer: only three reads fit.
    for (int k = 0; k < 5; k++) upq[1].push_back(rnd(1));
    rdy_a[1] = 1'b0; rd_cnt = 0; unstable = 0; seen = 0; hold = '0;
    d_base = delivered[1];
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (last_rd[1]) rd_cnt++;
      if (last_v[1]) begin
        if (seen == 0) begin seen = 1; hold = last_d[1]; end
        else if (last_d[1] !== hold) unstable++;
      end
    end
    chk(1, "stall_rd_pulses", 64'(rd_cnt), 64'd3);
    chk(1, "stall_occupancy", 64'(last_occ[1]), 64'd3);
    chk(1, "stall_data_changes", 64'(unstable), 64'd0);
    rdy_a[1] = 1'b1;
    repeat (12) cycle();
    chk(1, "stall_drain_delivered", 64'(delivered[1] - d_base), 64'd5);

    // Flush with two words buffered and one in flight.
    for (int k = 0; k < 5; k++) upq[1].push_back(rnd(1));
    rdy_a[1] = 1'b0;
    repeat (4) cycle();
    flush_a[1] = 1'b1;
    cycle();
    flush_a[1] = 1'b0;
    chk(1, "flush_pre_occupancy", 64'(last_occ[1]), 64'd2);
    cycle();
    chk(1, "flush_next_valid", 64'(last_v[1]), 64'd0);
    chk(1, "flush_next_occupancy", 64'(last_occ[1]), 64'd0);
    d_base = delivered[1];
    rdy_a[1] = 1'b1;
    repeat (12) cycle();
    chk(1, "flush_after_delivered", 64'(delivered[1] - d_base), 64'd2);

    // Gappy upstream and random back-pressure on both instances.
    d_base = delivered[0]; d_base1 = delivered[1];
    for (int k = 0; k < 40; k++) begin
      upq[0].push_back(rnd(0));
      upq[1].push_back(rnd(1));
    end
    for (int n = 0; n < 300; n++) begin
      fe[0] = cyc[0]; fe[1] = cyc[0];
      rdy_a[0] = 1'($urandom_range(0, 1));
      rdy_a[1] = 1'($urandom_range(0, 1));
      cycle();
    end
    fe[0] = 1'b0; fe[1] = 1'b0; rdy_a[0] = 1'b1; rdy_a[1] = 1'b1;
    for (int n = 0; n < 80 && (upq[0].size() + upq[1].size() +
                               exq[0].size() + exq[1].size()) != 0; n++) cycle();
    chk(0, "gappy_delivered", 64'(delivered[0] - d_base), 64'd40);
    chk(1, "gappy_delivered", 64'(delivered[1] - d_base1), 64'd40);

    // Reset pulse mid-stream, then a clean restart.
    for (int k = 0; k < 20; k++) begin
      upq[0].push_back(rnd(0));
      upq[1].push_back(rnd(1));
    end
    repeat (6) cycle();
    rst_pulse = 1'b1;
    cycle();
    rem0 = upq[0].size(); rem1 = upq[1].size();
    d_base = delivered[0]; d_base1 = delivered[1];
    for (int n = 0; n < 60 && (upq[0].size() + upq[1].size() +
                               exq[0].size() + exq[1].size()) != 0; n++) cycle();
    chk(0, "restart_delivered", 64'(delivered[0] - d_base), 64'(rem0));
    chk(1, "restart_delivered", 64'(delivered[1] - d_base1), 64'(rem1));
    chk(0, "restart_drained", 64'(exq[0].size()), 64'd0);

    // Long run for the statistic counter.
    d_base = delivered[0];
    for (int n = 0; n < 70100 && (delivered[0] - d_base) < 70000; n++) begin
      if (upq[0].size() < 4) upq[0].push_back(rnd(0));
      cycle();
    end
    chk(0, "long_transfers", 64'(delivered[0] - d_base), 64'd70000);
`ifdef FIFO_RD_STATS_EN
    chk(0, "long_word_count", 64'(wc0), 64'hFFFF);
`else
    chk(0, "long_word_count", 64'(wc0), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 9: data width, legal 4..36.
REQ-002 SHALL have parameter RD_LATENCY, default 1: cycles from fifo_rd_en high to valid fifo_dout; legal values 1 and 2.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port fifo_empty  in  1  empty flag of the upstream standard-mode FIFO.
REQ-006 SHALL have port fifo_rd_en  out  1  read strobe to the upstream FIFO.
REQ-007 SHALL have port fifo_dout  in  WIDTH  upstream read data, valid RD_LATENCY cycles after fifo_rd_en.
REQ-008 SHALL have port flush  in  1  synchronous discard of all buffered and in-flight words.
REQ-009 SHALL have port m_valid  out  1  stream word available.
REQ-010 SHALL have port m_ready  in  1  stream consumer accepts.
REQ-011 SHALL have port m_data  out  WIDTH  stream word.
REQ-012 SHALL have port occupancy  out  2  buffered word count.
REQ-013 SHALL have port word_count  out  16  delivered-word statistic.

Function
REQ-014 SHALL hold a circular buffer of D = RD_LATENCY+1 entries; write and read pointers wrap modulo D.
REQ-015 SHALL track in-flight reads in a RD_LATENCY-stage valid shift register; a stage exiting high writes fifo_dout into the buffer at that edge.
REQ-016 SHALL drive fifo_rd_en = !fifo_empty && !flush && (inflight + occupancy - (m_valid && m_ready)) < D, combinationally.
REQ-017 SHALL never overflow the buffer and never assert fifo_rd_en while fifo_empty is high.
REQ-018 SHALL drive m_valid = (occupancy != 0) from registers; m_data = buffer[rd_ptr].
REQ-019 SHALL transfer a word only on a cycle with m_valid && m_ready; it then advances rd_ptr by 1.
REQ-020 SHALL hold m_data stable while m_valid && !m_ready.
REQ-021 SHALL have latency RD_LATENCY+1 cycles from fifo_rd_en (empty buffer) to m_valid.
REQ-022 SHALL sustain one word per cycle while fifo_empty is low and m_ready is held high.
REQ-023 SHALL, on simultaneous arrival and pop, keep occupancy unchanged; an arrival into a full buffer is impossible by REQ-016.
REQ-024 SHALL, on a flush cycle: clear pointers, occupancy and all in-flight stages; force fifo_rd_en low; m_valid low from the next cycle; words returning after the flush are discarded.
REQ-025 SHALL give flush priority over a same-cycle pop and a same-cycle arrival.

Reset
REQ-026 SHALL on rst_n low asynchronously clear m_valid, occupancy, pointers, in-flight stages and word_count to 0; m_data reads 0.
REQ-027 SHALL hold fifo_rd_en low while rst_n is low; reset asserted mid-transfer discards all words.

Configuration
REQ-028 SHALL, with FIFO_RD_STATS_EN defined, increment word_count by 1 on each transfer, saturating at 16'hFFFF, cleared only by reset.
REQ-029 SHALL, without FIFO_RD_STATS_EN, tie word_count to 0 and build no counter logic.

Structure
REQ-030 SHALL place the legal RD_LATENCY range and the buffer-depth constant in the shared package fifo_rd_pkg.
REQ-031 SHALL implement the circular buffer as one sub-module, fifo_rd_buf; the credit and in-flight logic stays in the top level.

Verification
REQ-032 SHALL cover: RD_LATENCY=1, 8 words in upstream, m_ready=1 -> fifo_rd_en high 8 consecutive cycles, 8 words out in order, m_valid high 8 consecutive cycles.
REQ-033 SHALL cover: RD_LATENCY=2, WIDTH=36, m_ready=0 with 5 words upstream -> fifo_rd_en pulses exactly 3 times, occupancy saturates at 3, m_data stable.
REQ-034 SHALL cover: flush while 1 word is in flight and occupancy=2 -> next cycle m_valid=0, occupancy=0; the returning word is never output.
REQ-035 SHALL cover: fifo_empty toggled every cycle, random m_ready -> no read while empty, output order matches input, no loss or duplicate.
REQ-036 SHALL cover: rst_n low for 1 cycle mid-stream -> all outputs 0 immediately; stream restarts cleanly after release.
REQ-037 SHALL cover: with FIFO_RD_STATS_EN, 70000 transfers -> word_count = 16'hFFFF; without the macro, word_count = 0 throughout.
